mdu_seq: RTL

//  Multi-cycle sequencer for RV32M unsigned multiply/divide (MUL, MULHU, DIVU, REMU).

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle mul/div sequencer: ALU control codes
// (must track the core ALU encoding), MDU op codes and FSM state encodings.
package mdu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// RV32M unsigned MUL/MULHU/DIVU/REMU sequencer driving the core's shared ALU,
// one iteration per cycle. Define MDU_DIV0_FAST_EN to finish divide-by-zero at accept.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_res
);

    localparam int CW = $clog2(ITER) + 1;

    mdu_state_e      state;
    mdu_op_e         op_q;
    logic [CW-1:0]   cnt;
    // hi doubles as the remainder and lo as the quotient: both ops start as {0, rs1}
    logic [XLEN-1:0] hi, lo, opb;
    logic [XLEN-1:0] hi_n, lo_n;
    logic [XLEN:0]   r33;
    logic            is_div;

    assign is_div  = op_q[1];
    assign alu_own = busy;
    assign r33     = {hi, lo[XLEN-1]};

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        if (state == S_CALC) begin
            alu_b = opb;
            if (is_div) begin
                alu_ctrl = ALU_SUB;
                alu_a    = r33[XLEN-1:0];
            end else begin
                alu_a    = hi;
            end
        end
    end

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (is_div) begin
            // r33[XLEN] set means the shifted remainder already exceeds any divisor
            if (r33[XLEN] || (r33[XLEN-1:0] >= opb)) begin
                hi_n = alu_res;
                lo_n = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_n = r33[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            hi_n = {(alu_res < hi), alu_res[XLEN-1:1]};
            lo_n = {alu_res[0], lo[XLEN-1:1]};
        end else begin
            hi_n = {1'b0, hi[XLEN-1:1]};
            lo_n = {hi[0], lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= MDU_MUL;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= mdu_op_e'(op);
                        opb  <= rs2;
                        hi   <= '0;
                        lo   <= rs1;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef MDU_DIV0_FAST_EN
                        if (op[1] && (rs2 == '0)) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= op[0] ? rs1 : '1;
                        end else begin
                            state  <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        // op[0] selects the upper/remainder half for MULHU and REMU
                        result <= op_q[0] ? hi_n : lo_n;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
